// File: rtl/mem_access_unit.sv
//------------------------------------------------------------------------------
// Module   : mem_access_unit
// Brief    : Turns multicycle-controller memory strobes into one req/ack
//            transaction; holds IR and MDR. Optional: MISALIGN_CHECK_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_access_unit #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic          ior_d,
  input  logic          ir_write,
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] alu_out,
  input  logic [DW-1:0] wdata,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [DW-1:0] instr,
  output logic [5:0]    opcode,
  output logic [DW-1:0] mdr,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack
);

  localparam int             c_cnt_w  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit             c_tmo_en = (TIMEOUT > 0);
  localparam logic [c_cnt_w-1:0] c_tmo = c_cnt_w'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [AW-1:0]        r_addr;
  logic                 r_we;
  logic [DW-1:0]        r_wdata;
  logic                 r_irw;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [DW-1:0]        r_instr;
  logic [DW-1:0]        r_mdr;
  logic                 r_done;
  logic                 r_err;

  logic [AW-1:0]        w_sel_addr;
  logic [c_cnt_w-1:0]   w_cnt_inc;
  logic                 w_misalign;
  logic                 w_launch;
  logic                 w_cnt_en;
  logic                 w_done_set;
  logic                 w_err_set;
  logic                 w_ld_mdr;
  logic                 w_ld_ir;

  assign w_sel_addr = ior_d ? alu_out : pc;
  assign w_cnt_inc  = r_cnt + 1'b1;

`ifdef MISALIGN_CHECK_EN
  assign w_misalign = |w_sel_addr[1:0];
`else
  assign w_misalign = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_launch   = 1'b0;
    w_cnt_en   = 1'b0;
    w_done_set = 1'b0;
    w_err_set  = 1'b0;
    w_ld_mdr   = 1'b0;
    w_ld_ir    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_read ^ mem_write) begin
          if (w_misalign) begin
            w_err_set = 1'b1;
            w_next    = S_HOLD;
          end else begin
            w_launch = 1'b1;
            w_next   = S_REQ;
          end
        end else if (mem_read & mem_write) begin
          w_err_set = 1'b1;
          w_next    = S_HOLD;
        end
      end
      S_REQ: begin
        // An ack in the final timeout cycle still completes normally.
        if (m_ack) begin
          w_done_set = 1'b1;
          w_ld_mdr   = ~r_we;
          w_ld_ir    = ~r_we & r_irw;
          w_next     = S_HOLD;
        end else begin
          w_cnt_en = 1'b1;
          if (c_tmo_en && (w_cnt_inc == c_tmo)) begin
            w_err_set = 1'b1;
            w_next    = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!mem_read && !mem_write) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_irw   <= 1'b0;
      r_cnt   <= '0;
      r_instr <= '0;
      r_mdr   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= w_done_set;
      r_err  <= w_err_set;
      if (w_launch) begin
        r_addr  <= w_sel_addr;
        r_we    <= mem_write;
        r_wdata <= wdata;
        r_irw   <= ir_write;
        r_cnt   <= '0;
      end else if (w_cnt_en) begin
        r_cnt <= w_cnt_inc;
      end
      if (w_ld_mdr) r_mdr   <= m_rdata;
      if (w_ld_ir)  r_instr <= m_rdata;
    end
  end

  // Request is a direct decode of REQ so an async reset drops it at once.
  assign m_req   = (r_state == S_REQ);
  assign busy    = (r_state == S_REQ);
  assign m_we    = r_we;
  assign m_addr  = r_addr;
  assign m_wdata = r_wdata;
  assign done    = r_done;
  assign err     = r_err;
  assign instr   = r_instr;
  assign mdr     = r_mdr;
  assign opcode  = r_instr[31:26];

endmodule

`default_nettype wire
